validador_pecas: RTL and testbench



---
 rtl/validador_pecas.sv | 200 ++++++++++++++++++++
 tb/tb_validador_pecas.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/validador_pecas.sv
`default_nettype none
// ============================================================================
// Module : validador_pecas
// Brief  : Validates piece placements cell by cell and commits legal pieces
//          into per-player 8x8 boards. Define VALIDADOR_ADJACENCIA_EN to
//          also reject pieces touching an occupied cell orthogonally.
// Rev    : 1.0
// ============================================================================
module validador_pecas (
  input  logic       clk,
  input  logic       reset,
  input  logic       valida,
  input  logic [2:0] tipo,
  input  logic       jogador,
  input  logic [2:0] X1,
  input  logic [2:0] Y1,
  input  logic       direcao,
  input  logic [2:0] orientacao,
  output logic       conflito,
  output logic       valido,
  output logic       pronto,
  output logic       ocupado,
  input  logic       rd_jogador,
  input  logic [2:0] rd_x,
  input  logic [2:0] rd_y,
  output logic       rd_ocupado
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_valida_q;
  logic [2:0]  r_tipo;
  logic        r_jogador;
  logic [2:0]  r_x1, r_y1;
  logic        r_dir;
  logic [2:0]  r_ori;
  logic [2:0]  r_idx;
  logic        r_acc;
  logic [63:0] r_board0, r_board1;

  logic        w_req;
  logic        w_tipo_ok;
  logic [2:0]  w_last_idx;
  logic [63:0] w_board_tgt;
  logic [7:0]  w_off;
  logic [3:0]  w_cx, w_cy;
  logic        w_oob;
  logic        w_cell_conf;
  logic [63:0] w_mask;

  // Returns {dx, dy} of cell i relative to the anchor.
  function automatic logic [7:0] cell_offset(input logic [2:0] t, input logic d,
                                             input logic [2:0] o, input logic [2:0] i);
    logic [1:0] rot;
    logic [7:0] off;
    case (o)
      3'd1, 3'd5: rot = 2'd1;
      3'd2, 3'd6: rot = 2'd2;
      3'd3, 3'd7: rot = 2'd3;
      default:    rot = 2'd0;
    endcase
    off = 8'd0;
    if (t == 3'd2) begin
      case ({rot, i})
        5'b00_001: off = {4'd1, 4'd1};
        5'b00_010: off = {4'd2, 4'd0};
        5'b01_001: off = {4'd1, 4'd1};
        5'b01_010: off = {4'd0, 4'd2};
        5'b10_000: off = {4'd0, 4'd1};
        5'b10_001: off = {4'd1, 4'd0};
        5'b10_010: off = {4'd2, 4'd1};
        5'b11_000: off = {4'd1, 4'd0};
        5'b11_001: off = {4'd0, 4'd1};
        5'b11_010: off = {4'd1, 4'd2};
        default:   off = 8'd0;
      endcase
    end else if (d) begin
      off = {4'd0, 1'b0, i};
    end else begin
      off = {1'b0, i, 4'd0};
    end
    return off;
  endfunction

  assign w_req       = valida & ~r_valida_q & (r_state == S_IDLE);
  assign w_tipo_ok   = (r_tipo <= 3'd4);
  assign w_last_idx  = w_tipo_ok ? r_tipo : 3'd0;
  assign w_board_tgt = r_jogador ? r_board1 : r_board0;
  assign rd_ocupado  = rd_jogador ? r_board1[{rd_y, rd_x}] : r_board0[{rd_y, rd_x}];

  always_comb begin
    w_off       = cell_offset(r_tipo, r_dir, r_ori, r_idx);
    w_cx        = {1'b0, r_x1} + w_off[7:4];
    w_cy        = {1'b0, r_y1} + w_off[3:0];
    w_oob       = w_cx[3] | w_cy[3];
    w_cell_conf = ~w_tipo_ok | w_oob | w_board_tgt[{w_cy[2:0], w_cx[2:0]}];
`ifdef VALIDADOR_ADJACENCIA_EN
    if (!w_oob) begin
      if (w_cx[2:0] != 3'd0) w_cell_conf = w_cell_conf | w_board_tgt[{w_cy[2:0], w_cx[2:0] - 3'd1}];
      if (w_cx[2:0] != 3'd7) w_cell_conf = w_cell_conf | w_board_tgt[{w_cy[2:0], w_cx[2:0] + 3'd1}];
      if (w_cy[2:0] != 3'd0) w_cell_conf = w_cell_conf | w_board_tgt[{w_cy[2:0] - 3'd1, w_cx[2:0]}];
      if (w_cy[2:0] != 3'd7) w_cell_conf = w_cell_conf | w_board_tgt[{w_cy[2:0] + 3'd1, w_cx[2:0]}];
    end
`endif
  end

  // All cells of the latched piece, used for the single-edge commit.
  always_comb begin : commit_mask
    logic [7:0] m_off;
    logic [3:0] m_x, m_y;
    w_mask = '0;
    m_off  = '0;
    m_x    = '0;
    m_y    = '0;
    for (int i = 0; i < 5; i++) begin
      if (3'(i) <= w_last_idx) begin
        m_off = cell_offset(r_tipo, r_dir, r_ori, 3'(i));
        m_x   = {1'b0, r_x1} + m_off[7:4];
        m_y   = {1'b0, r_y1} + m_off[3:0];
        if (!m_x[3] && !m_y[3]) w_mask[{m_y[2:0], m_x[2:0]}] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_state_next = S_CHECK;
      S_CHECK:  if (r_idx == w_last_idx) w_state_next = S_RESULT;
      S_RESULT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valida_q <= 1'b0;
      r_tipo     <= '0;
      r_jogador  <= 1'b0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_dir      <= 1'b0;
      r_ori      <= '0;
      r_idx      <= '0;
      r_acc      <= 1'b0;
      r_board0   <= '0;
      r_board1   <= '0;
      conflito   <= 1'b0;
      valido     <= 1'b0;
      pronto     <= 1'b0;
      ocupado    <= 1'b0;
    end else begin
      r_valida_q <= valida;
      pronto     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_tipo    <= tipo;
            r_jogador <= jogador;
            r_x1      <= X1;
            r_y1      <= Y1;
            r_dir     <= direcao;
            r_ori     <= orientacao;
            r_idx     <= '0;
            r_acc     <= 1'b0;
            valido    <= 1'b0;
            ocupado   <= 1'b1;
          end
        end
        S_CHECK: begin
          r_acc <= r_acc | w_cell_conf;
          r_idx <= r_idx + 3'd1;
        end
        S_RESULT: begin
          conflito <= r_acc;
          valido   <= 1'b1;
          pronto   <= 1'b1;
          ocupado  <= 1'b0;
          if (!r_acc) begin
            if (r_jogador) r_board1 <= r_board1 | w_mask;
            else           r_board0 <= r_board0 | w_mask;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_validador_pecas.sv
`default_nettype none
// ============================================================================
// Module : tb_validador_pecas
// Brief  : Directed vector bench for validador_pecas.
// Rev    : 1.0
// ============================================================================
module tb_validador_pecas;

  logic       clk = 1'b0;
  logic       reset;
  logic       valida;
  logic [2:0] tipo;
  logic       jogador;
  logic [2:0] X1, Y1;
  logic       direcao;
  logic [2:0] orientacao;
  logic       conflito, valido, pronto, ocupado;
  logic       rd_jogador;
  logic [2:0] rd_x, rd_y;
  logic       rd_ocupado;

  int n_checks = 0;
  int n_errors = 0;

  validador_pecas dut (
    .clk        (clk),
    .reset      (reset),
    .valida     (valida),
    .tipo       (tipo),
    .jogador    (jogador),
    .X1         (X1),
    .Y1         (Y1),
    .direcao    (direcao),
    .orientacao (orientacao),
    .conflito   (conflito),
    .valido     (valido),
    .pronto     (pronto),
    .ocupado    (ocupado),
    .rd_jogador (rd_jogador),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_ocupado (rd_ocupado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] tipo;
    logic       jog;
    logic [2:0] x;
    logic [2:0] y;
    logic       dir;
    logic [2:0] ori;
    logic       conf;
    int         lat;
  } req_t;

  typedef struct {
    logic       jog;
    logic [2:0] x;
    logic [2:0] y;
    logic       occ;
  } rd_t;

  req_t reqs[11];
  rd_t  rds[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic j, input logic [2:0] x,
                          input logic [2:0] y, input logic exp);
    rd_jogador = j;
    rd_x       = x;
    rd_y       = y;
    #1;
    check(name, {31'd0, rd_ocupado}, {31'd0, exp});
  endtask

  task automatic do_req(input int k, input req_t r);
    int   cyc;
    int   busy;
    logic got;
    @(negedge clk);
    tipo       = r.tipo;
    jogador    = r.jog;
    X1         = r.x;
    Y1         = r.y;
    direcao    = r.dir;
    orientacao = r.ori;
    valida     = 1'b1;
    @(negedge clk);
    valida = 1'b0;
    check($sformatf("req%0d valido_cleared", k), {31'd0, valido}, 32'd0);
    cyc  = 1;
    busy = 0;
    got  = 1'b0;
    while (cyc <= 12) begin
      if (pronto) begin
        got = 1'b1;
        break;
      end
      if (ocupado) busy++;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("req%0d pronto_seen", k), {31'd0, got}, 32'd1);
    check($sformatf("req%0d latency", k), cyc - 1, r.lat);
    check($sformatf("req%0d busy_cycles", k), busy, r.lat);
    check($sformatf("req%0d conflito", k), {31'd0, conflito}, {31'd0, r.conf});
    check($sformatf("req%0d valido", k), {31'd0, valido}, 32'd1);
    @(negedge clk);
    check($sformatf("req%0d pronto_pulse", k), {31'd0, pronto}, 32'd0);
  endtask

  initial begin
    int   cnt;
    req_t r;
    logic adj_exp;
`ifdef VALIDADOR_ADJACENCIA_EN
    adj_exp = 1'b1;
`else
    adj_exp = 1'b0;
`endif
    //         tipo  jog   x     y     dir   ori   conf     lat
    reqs[0]  = '{3'd4, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0,    6};
    reqs[1]  = '{3'd1, 1'b0, 3'd3, 3'd0, 1'b1, 3'd0, 1'b1,    3};
    reqs[2]  = '{3'd1, 1'b1, 3'd3, 3'd0, 1'b1, 3'd0, 1'b0,    3};
    reqs[3]  = '{3'd3, 1'b0, 3'd5, 3'd0, 1'b0, 3'd0, 1'b1,    5};
    reqs[4]  = '{3'd6, 1'b0, 3'd1, 3'd6, 1'b0, 3'd0, 1'b1,    2};
    reqs[5]  = '{3'd2, 1'b0, 3'd2, 3'd2, 1'b0, 3'd4, 1'b0,    4};
    reqs[6]  = '{3'd0, 1'b0, 3'd0, 3'd1, 1'b0, 3'd0, adj_exp, 2};
    reqs[7]  = '{3'd2, 1'b1, 3'd6, 3'd6, 1'b0, 3'd1, 1'b1,    4};
    reqs[8]  = '{3'd2, 1'b1, 3'd5, 3'd0, 1'b1, 3'd3, 1'b0,    4};
    reqs[9]  = '{3'd4, 1'b1, 3'd7, 3'd3, 1'b1, 3'd0, 1'b0,    6};
    reqs[10] = '{3'd0, 1'b1, 3'd7, 3'd7, 1'b0, 3'd0, 1'b1,    2};

    rds[0]  = '{1'b0, 3'd0, 3'd0, 1'b1};
    rds[1]  = '{1'b0, 3'd4, 3'd0, 1'b1};
    rds[2]  = '{1'b0, 3'd5, 3'd0, 1'b0};
    rds[3]  = '{1'b0, 3'd3, 3'd1, 1'b0};
    rds[4]  = '{1'b0, 3'd2, 3'd2, 1'b1};
    rds[5]  = '{1'b0, 3'd3, 3'd3, 1'b1};
    rds[6]  = '{1'b0, 3'd4, 3'd2, 1'b1};
    rds[7]  = '{1'b0, 3'd3, 3'd2, 1'b0};
    rds[8]  = '{1'b0, 3'd7, 3'd0, 1'b0};
    rds[9]  = '{1'b0, 3'd0, 3'd1, ~adj_exp};
    rds[10] = '{1'b1, 3'd3, 3'd0, 1'b1};
    rds[11] = '{1'b1, 3'd3, 3'd1, 1'b1};
    rds[12] = '{1'b1, 3'd0, 3'd0, 1'b0};
    rds[13] = '{1'b1, 3'd6, 3'd0, 1'b1};
    rds[14] = '{1'b1, 3'd5, 3'd1, 1'b1};
    rds[15] = '{1'b1, 3'd6, 3'd2, 1'b1};
    rds[16] = '{1'b1, 3'd6, 3'd6, 1'b0};
    rds[17] = '{1'b1, 3'd7, 3'd7, 1'b1};
    rds[18] = '{1'b1, 3'd7, 3'd3, 1'b1};
    rds[19] = '{1'b1, 3'd7, 3'd2, 1'b0};
    rds[20] = '{1'b1, 3'd0, 3'd7, 1'b1};
    rds[21] = '{1'b0, 3'd7, 3'd7, 1'b1};
    rds[22] = '{1'b0, 3'd6, 3'd7, 1'b0};

    reset = 1'b0; valida = 1'b0; tipo = '0; jogador = 1'b0; X1 = '0; Y1 = '0;
    direcao = 1'b0; orientacao = '0; rd_jogador = 1'b0; rd_x = '0; rd_y = '0;
    repeat (3) @(negedge clk);
    check("reset conflito", {31'd0, conflito}, 32'd0);
    check("reset valido", {31'd0, valido}, 32'd0);
    check("reset pronto", {31'd0, pronto}, 32'd0);
    check("reset ocupado", {31'd0, ocupado}, 32'd0);
    rd_check("reset board", 1'b0, 3'd0, 3'd0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 11; k++) do_req(k, reqs[k]);

    // Holding valida high must yield exactly one result.
    @(negedge clk);
    tipo = 3'd0; jogador = 1'b1; X1 = 3'd0; Y1 = 3'd7; valida = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pronto) cnt++;
    end
    check("hold pronto_count", cnt, 1);
    check("hold conflito", {31'd0, conflito}, 32'd0);
    valida = 1'b0;
    repeat (2) @(negedge clk);

    // A rising valida while in RESULT is not a request.
    tipo = 3'd0; jogador = 1'b0; X1 = 3'd7; Y1 = 3'd7; valida = 1'b1;
    @(negedge clk);
    valida = 1'b0;
    @(negedge clk);
    valida = 1'b1;
    @(negedge clk);
    check("rise_in_result pronto", {31'd0, pronto}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ocupado || pronto) cnt++;
    end
    check("rise_in_result no_retrigger", cnt, 0);
    valida = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 23; k++)
      rd_check($sformatf("board%0d", k), rds[k].jog, rds[k].x, rds[k].y, rds[k].occ);

    r = '{3'd7, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 2};
    do_req(11, r);

    // Reset in the middle of CHECK aborts with no commit.
    @(negedge clk);
    tipo = 3'd4; jogador = 1'b0; X1 = 3'd0; Y1 = 3'd5; direcao = 1'b0; valida = 1'b1;
    @(negedge clk);
    valida = 1'b0;
    @(negedge clk);
    check("midreset busy_before", {31'd0, ocupado}, 32'd1);
    reset = 1'b0;
    #1;
    check("midreset conflito", {31'd0, conflito}, 32'd0);
    check("midreset ocupado", {31'd0, ocupado}, 32'd0);
    check("midreset valido", {31'd0, valido}, 32'd0);
    rd_check("midreset b0", 1'b0, 3'd0, 3'd0, 1'b0);
    rd_check("midreset b1", 1'b1, 3'd3, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pronto || ocupado) cnt++;
    end
    check("midreset no_resume", cnt, 0);
    rd_check("midreset no_commit", 1'b0, 3'd0, 3'd5, 1'b0);
    rd_check("midreset no_commit2", 1'b0, 3'd2, 3'd5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
